// File: rtl/pe_weight_load_ctrl_pkg.sv
// Shared definitions for the PE weight-load controller: FSM state encoding
// and the default bus widths used by the PE weight write port.
package pe_weight_load_ctrl_pkg;

  localparam int WEIGHT_ADDR_W = 32;
  localparam int WEIGHT_DATA_W = 16;
  localparam int CHECKSUM_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wload_state_e;

endpackage : pe_weight_load_ctrl_pkg

// File: rtl/pe_wload_checksum.sv
// Running checksum over the accepted weight words of one load, compared with
// the expected value in the DONE cycle. Only instantiated when the top is
// built with WEIGHT_LOAD_CHECKSUM_EN.
module pe_wload_checksum
  import pe_weight_load_ctrl_pkg::*;
#(
  parameter int DATA_W = WEIGHT_DATA_W,
  parameter int SUM_W  = CHECKSUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,           // accepted start: restart sum, latch expected
  input  logic [SUM_W-1:0]  cfg_checksum,
  input  logic              acc_en,        // stream handshake
  input  logic [DATA_W-1:0] acc_data,
  input  logic              chk_en,        // high in the DONE cycle
  output logic              sum_ok,
  output logic              checksum_err
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] exp_q;

  // The sum is complete in DONE because the last word was added on the edge entering DONE.
  assign sum_ok = (sum_q == exp_q);

  // Accumulate zero-extended words; the error flag is sticky until the next load starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= '0;
      exp_q        <= '0;
      checksum_err <= 1'b0;
    end else if (clr) begin
      sum_q        <= '0;
      exp_q        <= cfg_checksum;
      checksum_err <= 1'b0;
    end else begin
      if (acc_en) begin
        sum_q <= sum_q + SUM_W'(acc_data);
      end
      if (chk_en && !sum_ok) begin
        checksum_err <= 1'b1;
      end
    end
  end

endmodule : pe_wload_checksum

// File: rtl/pe_weight_load_ctrl.sv
// Weight-load sequencer for one PE layer. Streams cfg_num_words weight words
// into the PE weight write bus at consecutive addresses from cfg_base_addr and
// keeps the feature-map handshake closed until a full load has completed.
// Optional build macro: WEIGHT_LOAD_CHECKSUM_EN adds an expected-checksum
// check; a mismatch raises checksum_err and keeps the PE gated.
module pe_weight_load_ctrl
  import pe_weight_load_ctrl_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int ADDR_W = WEIGHT_ADDR_W,
  parameter int DATA_W = WEIGHT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_words,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] weight_wr_data,
  output logic [ADDR_W-1:0] weight_wr_addr,
  output logic              weight_wr_en,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  input  logic              fm_valid,
  output logic              fm_ready,
  output logic              pe_i_valid,
  input  logic              pe_ready
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  input  logic [CHECKSUM_W-1:0] cfg_checksum,
  output logic                  checksum_err
`endif
);

  wload_state_e      state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;
  logic              start_acc;
  logic              handshake;
  logic              last_word;
  logic              chk_ok;

  // Status and stream-ready are plain decodes of the state register.
  assign s_ready   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign start_acc = start && (state == IDLE);
  assign handshake = s_valid && s_ready;
  assign last_word = (idx_q == (count_q - CNT_W'(1)));

  // Feature-map passthrough: open only when a complete load is in place.
  assign fm_ready   = pe_ready && loaded && !busy;
  assign pe_i_valid = fm_valid && loaded && !busy;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  pe_wload_checksum #(
    .DATA_W (DATA_W),
    .SUM_W  (CHECKSUM_W)
  ) u_checksum (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (start_acc),
    .cfg_checksum (cfg_checksum),
    .acc_en       (handshake),
    .acc_data     (s_data),
    .chk_en       (done),
    .sum_ok       (chk_ok),
    .checksum_err (checksum_err)
  );
`else
  assign chk_ok = 1'b1;
`endif

  // FSM, word index and the registered PE write port.
  // NOTE: asynchronous reset clears everything at once, so a mid-load reset aborts
  // the load and drops loaded without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_data <= '0;
      weight_wr_addr <= '0;
      loaded         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge
      // values; blocking ones would make idx_q/state updates order-dependent.
      weight_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q  <= cfg_base_addr;
            count_q <= cfg_num_words;
            idx_q   <= '0;
            loaded  <= 1'b0;
            state   <= (cfg_num_words == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (handshake) begin
            weight_wr_en   <= 1'b1;
            weight_wr_data <= s_data;
            weight_wr_addr <= base_q + ADDR_W'(idx_q);
            idx_q          <= idx_q + CNT_W'(1);
            if (last_word) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          loaded <= chk_ok;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : pe_weight_load_ctrl

// File: tb/tb_pe_weight_load_ctrl.sv
// Self-checking bench for pe_weight_load_ctrl: a transaction-level model of a
// weight load compared against the DUT every cycle, plus literal expectations
// for the directed scenarios.
module tb_pe_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [19:0] cfg_num_words = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;
  logic        busy, done, loaded;
  logic        fm_valid = 1'b0;
  logic        fm_ready, pe_i_valid;
  logic        pe_ready = 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [31:0] cfg_checksum = '0;
  logic        checksum_err;
`endif

  pe_weight_load_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_data (weight_wr_data),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_en   (weight_wr_en),
    .busy           (busy),
    .done           (done),
    .loaded         (loaded),
    .fm_valid       (fm_valid),
    .fm_ready       (fm_ready),
    .pe_i_valid     (pe_i_valid),
    .pe_ready       (pe_ready)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    .cfg_checksum   (cfg_checksum),
    .checksum_err   (checksum_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A load is "words still owed" plus "next address"; completion is a one-cycle
  // done window, after which the weights count as valid.
  bit          m_loading, m_done, m_loaded, m_wr_en;
  int          m_left;
  logic [31:0] m_next, m_wr_addr;
  logic [15:0] m_wr_data;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [31:0] m_sum, m_exp;
  bit          m_err;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_done = 0; m_loaded = 0; m_wr_en = 0; m_left = 0;
      m_next = '0; m_wr_addr = '0; m_wr_data = '0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      m_sum = '0; m_exp = '0; m_err = 0;
`endif
    end else begin
      m_wr_en = 0;
      if (m_done) begin
        m_done   = 0;
        m_loaded = 1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        if (m_sum != m_exp) begin
          m_err    = 1;
          m_loaded = 0;
        end
`endif
      end else if (m_loading) begin
        if (s_valid) begin
          m_wr_en   = 1;
          m_wr_addr = m_next;
          m_wr_data = s_data;
          m_next    = m_next + 32'd1;
          m_left    = m_left - 1;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
          m_sum = m_sum + {16'd0, s_data};
`endif
          if (m_left == 0) begin
            m_loading = 0;
            m_done    = 1;
          end
        end
      end else if (start) begin
        m_loaded = 0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        m_sum = '0; m_exp = cfg_checksum; m_err = 0;
`endif
        if (cfg_num_words == 0) begin
          m_done = 1;
        end else begin
          m_loading = 1;
          m_left    = int'(cfg_num_words);
          m_next    = cfg_base_addr;
        end
      end
    end
  end

  // Single compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("s_ready", s_ready, m_loading);
      check("busy", busy, m_loading | m_done);
      check("done", done, m_done);
      check("loaded", loaded, m_loaded);
      check("wr_en", weight_wr_en, m_wr_en);
      if (m_wr_en) begin
        check("wr_addr", weight_wr_addr, m_wr_addr);
        check("wr_data", weight_wr_data, m_wr_data);
      end
      check("fm_ready", fm_ready, pe_ready & m_loaded & ~(m_loading | m_done));
      check("pe_i_valid", pe_i_valid, fm_valid & m_loaded & ~(m_loading | m_done));
`ifdef WEIGHT_LOAD_CHECKSUM_EN
      check("checksum_err", checksum_err, m_err);
`endif
    end
  end

  // ---------------- event logs for literal checks ----------------
  logic [31:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  int          sent_cyc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (weight_wr_en === 1'b1) begin
      wr_addr_q.push_back(weight_wr_addr);
      wr_data_q.push_back(weight_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); sent_cyc_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [19:0] num);
    start = 1'b1; cfg_base_addr = base; cfg_num_words = num;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit v);
    s_data = d; s_valid = v;
    if (v) sent_cyc_q.push_back(cyc);
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  logic [15:0] t1_words[4];
  int          n0;

  initial begin
    t1_words[0] = 16'h0011; t1_words[1] = 16'h0022;
    t1_words[2] = 16'h0033; t1_words[3] = 16'h0044;

    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_wr_addr", weight_wr_addr, 32'd0);
    check("rst_wr_data", weight_wr_data, 16'd0);
    check("rst_loaded", loaded, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: base 23, four back-to-back words.
    clear_logs();
    do_start(32'd23, 20'd4);
    for (int i = 0; i < 4; i++) send(t1_words[i], 1'b1);
    s_valid = 1'b0;
    tick();
    check("t1_loaded_after_done", loaded, 1'b1);
    check("t1_nwrites", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check("t1_addr", wr_addr_q[i], 32'd23 + 32'(i));
      check("t1_data", wr_data_q[i], t1_words[i]);
      check("t1_latency", wr_cyc_q[i], sent_cyc_q[i] + 1);
    end
    check("t1_ndone", done_cyc_q.size(), 1);
    if (done_cyc_q.size() == 1 && wr_cyc_q.size() == 4)
      check("t1_done_on_last_wr", done_cyc_q[0], wr_cyc_q[3]);

    // T5: feature-map gating around a reload.
    fm_valid = 1'b1; pe_ready = 1'b1;
    #1;
    check("t5_pe_i_valid_open", pe_i_valid, 1'b1);
    check("t5_fm_ready_open", fm_ready, 1'b1);
    do_start(32'd200, 20'd1);
    check("t5_pe_i_valid_gated", pe_i_valid, 1'b0);
    check("t5_fm_ready_gated", fm_ready, 1'b0);
    send(16'hABCD, 1'b1);
    s_valid = 1'b0;
    check("t5_gated_in_done", fm_ready, 1'b0);
    tick();
    check("t5_reopen", pe_i_valid, 1'b1);
    fm_valid = 1'b0; pe_ready = 1'b0;

    // T2: three words with s_valid toggling.
    clear_logs();
    do_start(32'd7, 20'd3);
    send(16'h00A1, 1'b1); send(16'h0000, 1'b0);
    send(16'h00A2, 1'b1); send(16'h0000, 1'b0);
    send(16'h00A3, 1'b1);
    check("t2_s_ready_drop", s_ready, 1'b0);
    send(16'h00A4, 1'b1);
    s_valid = 1'b0;
    wait_idle();
    tick();
    check("t2_nwrites", wr_addr_q.size(), 3);
    if (wr_addr_q.size() == 3) begin
      check("t2_addr0", wr_addr_q[0], 32'd7);
      check("t2_addr2", wr_addr_q[2], 32'd9);
      check("t2_data2", wr_data_q[2], 16'h00A3);
      check("t2_gap01", wr_cyc_q[1] - wr_cyc_q[0], 2);
      check("t2_gap12", wr_cyc_q[2] - wr_cyc_q[1], 2);
    end

    // T3: zero-word load.
    clear_logs();
    n0 = cyc;
    do_start(32'd40, 20'd0);
    tick();
    check("t3_loaded", loaded, 1'b1);
    check("t3_nwrites", wr_addr_q.size(), 0);
    check("t3_ndone", done_cyc_q.size(), 1);
    if (done_cyc_q.size() == 1) check("t3_done_cycle", done_cyc_q[0], n0 + 1);

    // T4: start while busy is ignored.
    clear_logs();
    do_start(32'd100, 20'd5);
    send(16'h0100, 1'b1);
    start = 1'b1; cfg_base_addr = 32'd500; cfg_num_words = 20'd9;
    send(16'h0101, 1'b1);
    start = 1'b0;
    send(16'h0102, 1'b1); send(16'h0103, 1'b1); send(16'h0104, 1'b1);
    send(16'h0105, 1'b1);
    s_valid = 1'b0;
    wait_idle();
    tick();
    check("t4_nwrites", wr_addr_q.size(), 5);
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++)
      check("t4_addr", wr_addr_q[i], 32'd100 + 32'(i));
    check("t4_ndone", done_cyc_q.size(), 1);

    // Address wrap modulo 2^32.
    clear_logs();
    do_start(32'hFFFF_FFFE, 20'd3);
    send(16'h0E01, 1'b1); send(16'h0E02, 1'b1); send(16'h0E03, 1'b1);
    s_valid = 1'b0;
    wait_idle();
    check("wrap_nwrites", wr_addr_q.size(), 3);
    if (wr_addr_q.size() == 3) begin
      check("wrap_addr1", wr_addr_q[1], 32'hFFFF_FFFF);
      check("wrap_addr2", wr_addr_q[2], 32'h0000_0000);
    end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    cfg_checksum = 32'd3;
    do_start(32'd0, 20'd2);
    send(16'h0001, 1'b1); send(16'h0002, 1'b1);
    s_valid = 1'b0;
    wait_idle();
    check("cs_good_err", checksum_err, 1'b0);
    check("cs_good_loaded", loaded, 1'b1);
    cfg_checksum = 32'd4;
    do_start(32'd0, 20'd2);
    send(16'h0001, 1'b1); send(16'h0002, 1'b1);
    s_valid = 1'b0;
    wait_idle();
    check("cs_bad_err", checksum_err, 1'b1);
    check("cs_bad_loaded", loaded, 1'b0);
    cfg_checksum = 32'd0;
    do_start(32'd0, 20'd0);
    tick();
    check("cs_clear_err", checksum_err, 1'b0);
    check("cs_zero_loaded", loaded, 1'b1);
`endif

    // T6: reset in the middle of a load.
    do_start(32'd300, 20'd4);
    send(16'h0301, 1'b1);
    s_valid = 1'b1; s_data = 16'h0302;
    #2 rst_n = 1'b0;
    #1;
    check("t6_wr_en", weight_wr_en, 1'b0);
    check("t6_wr_addr", weight_wr_addr, 32'd0);
    check("t6_wr_data", weight_wr_data, 16'd0);
    check("t6_busy", busy, 1'b0);
    check("t6_loaded", loaded, 1'b0);
    check("t6_s_ready", s_ready, 1'b0);
    tick(); tick();
    s_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("t6_post_s_ready", s_ready, 1'b0);
    check("t6_post_loaded", loaded, 1'b0);
    check("t6_post_busy", busy, 1'b0);
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pe_weight_load_ctrl
